// File: rtl/mux_arb_if.sv
// Handshake bundle for mux_arb: N input channels (valid/ready/data),
// a fixed-mode channel select, and one registered output channel.
//   master : the side that drives channel data/valids, sel and out_ready
//   slave  : the arbiter itself (drives in_ready and the out_* bus)
interface mux_arb_if #(
   parameter int W  = 32,
   parameter int N  = 4,
   parameter int SW = 2
);
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_chan;

   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_valid, out_chan
   );

   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_valid, out_chan
   );
endinterface

// File: rtl/mux_arb.sv
// mux_arb: N-to-1 valid/ready multiplexer with a single-word output register.
//   MODE=0 : fixed mode, channel chosen by bus.sel (no grant if sel >= N)
//   MODE=1 : round-robin, search starts one past the last accepted channel
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      mux_arb_if.slave (in_data/in_valid/in_ready, sel,
//            out_data/out_valid/out_ready/out_chan)
// Throughput is one word per cycle: a held word may be replaced in the same
// cycle it is drained.
module mux_arb #(
   parameter int W    = 32,
   parameter int N    = 4,
   parameter int MODE = 1,
   parameter int SW   = 2
) (
   input logic      clk,
   input logic      reset_n,
   mux_arb_if.slave bus
);

   logic [W-1:0]  out_data_q;
   logic          out_valid_q;
   logic [SW-1:0] out_chan_q;
   logic [SW-1:0] ptr_q;

   logic          load_ok;
   logic          gnt_vld;
   logic [SW-1:0] gnt_idx;
   logic [W-1:0]  gnt_data;
   logic [N-1:0]  in_ready_d;
   logic          xfer;

   // Output register can take a word when empty or being drained now.
   assign load_ok = !out_valid_q || bus.out_ready;

   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (MODE == 0) begin
         if (int'(bus.sel) < N) begin
            gnt_vld = 1'b1;
            gnt_idx = bus.sel;
         end
      end else begin
         // Walk from the farthest candidate (ptr itself) to the nearest
         // (ptr+1); the last hit wins, so the nearest valid channel is taken.
         for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (bus.in_valid[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = SW'(idx);
            end
         end
      end
   end

   // One-hot ready; gated by reset so nothing is accepted during reset.
   always_comb begin
      in_ready_d = '0;
      gnt_data   = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SW'(i)) begin
            in_ready_d[i] = reset_n && load_ok && gnt_vld;
            gnt_data      = bus.in_data[i*W +: W];
         end
      end
   end

   assign xfer = |(in_ready_d & bus.in_valid);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= SW'(N-1);
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= gnt_data;
         out_chan_q  <= gnt_idx;
         if (MODE != 0) ptr_q <= gnt_idx;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_d;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: a round-robin instance and a fixed-mode
// instance share clock and reset; each scenario task checks its own results.
module tb_mux_arb;
   localparam int W = 32, N = 4, SW = 2;

   logic clk = 1'b0;
   logic reset_n;
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   always #5 clk = ~clk;

   mux_arb_if #(.W(W), .N(N), .SW(SW)) bus_rr ();
   mux_arb_if #(.W(W), .N(N), .SW(SW)) bus_fx ();

   mux_arb #(.W(W), .N(N), .MODE(1), .SW(SW)) u_rr (.clk(clk), .reset_n(reset_n), .bus(bus_rr));
   mux_arb #(.W(W), .N(N), .MODE(0), .SW(SW)) u_fx (.clk(clk), .reset_n(reset_n), .bus(bus_fx));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n         = 1'b0;
      bus_rr.in_valid = 4'b1111;
      bus_rr.out_ready = 1'b1;
      bus_fx.in_valid = 4'b1111;
      bus_fx.out_ready = 1'b1;
      #1;
      tot_cnt++; if (bus_rr.in_ready !== 4'b0000) $display("FAIL rst_rr_ready got=%b exp=0000", bus_rr.in_ready); else pass_cnt++;
      tot_cnt++; if (bus_fx.in_ready !== 4'b0000) $display("FAIL rst_fx_ready got=%b exp=0000", bus_fx.in_ready); else pass_cnt++;
      tick();
      tick();
      tot_cnt++; if (bus_rr.out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus_rr.out_valid); else pass_cnt++;
      tot_cnt++; if (bus_rr.out_data !== 32'h0) $display("FAIL rst_data got=%h exp=0", bus_rr.out_data); else pass_cnt++;
      tot_cnt++; if (bus_rr.out_chan !== 2'd0) $display("FAIL rst_chan got=%0d exp=0", bus_rr.out_chan); else pass_cnt++;
      tot_cnt++; if (bus_fx.out_valid !== 1'b0) $display("FAIL rst_fx_valid got=%b exp=0", bus_fx.out_valid); else pass_cnt++;
   endtask

   task automatic test_rr_fairness();
      logic [SW-1:0] exp_chan [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      bus_fx.in_valid = 4'b0000;
      bus_rr.in_valid = 4'b1111;
      bus_rr.out_ready = 1'b1;
      reset_n = 1'b1;
      #1;
      tot_cnt++; if (bus_rr.in_ready !== 4'b0001) $display("FAIL rr_first_ready got=%b exp=0001", bus_rr.in_ready); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         tick();
         tot_cnt++; if (bus_rr.out_valid !== 1'b1) $display("FAIL rr_valid[%0d] got=%b exp=1", k, bus_rr.out_valid); else pass_cnt++;
         tot_cnt++; if (bus_rr.out_chan !== exp_chan[k]) $display("FAIL rr_chan[%0d] got=%0d exp=%0d", k, bus_rr.out_chan, exp_chan[k]); else pass_cnt++;
         tot_cnt++; if (bus_rr.out_data !== 32'h1000_0000 + 32'(exp_chan[k])) $display("FAIL rr_data[%0d] got=%h exp=%h", k, bus_rr.out_data, 32'h1000_0000 + 32'(exp_chan[k])); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      bus_rr.in_valid = 4'b0000;
      bus_rr.out_ready = 1'b1;
      tick();
      tot_cnt++; if (bus_rr.out_valid !== 1'b0) $display("FAIL bp_predrain got=%b exp=0", bus_rr.out_valid); else pass_cnt++;
      bus_rr.in_data[31:0] = 32'hDEAD_BEEF;
      bus_rr.in_valid  = 4'b0001;
      bus_rr.out_ready = 1'b0;
      tick();
      tot_cnt++; if (bus_rr.out_data !== 32'hDEAD_BEEF) $display("FAIL bp_load got=%h exp=deadbeef", bus_rr.out_data); else pass_cnt++;
      bus_rr.in_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         tot_cnt++; if (bus_rr.in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus_rr.in_ready); else pass_cnt++;
         tick();
         tot_cnt++; if (bus_rr.out_data !== 32'hDEAD_BEEF || bus_rr.out_valid !== 1'b1 || bus_rr.out_chan !== 2'd0)
            $display("FAIL bp_hold[%0d] got=%h/%b/%0d exp=deadbeef/1/0", k, bus_rr.out_data, bus_rr.out_valid, bus_rr.out_chan);
         else pass_cnt++;
      end
      bus_rr.in_valid  = 4'b0000;
      bus_rr.out_ready = 1'b1;
      tick();
      tot_cnt++; if (bus_rr.out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", bus_rr.out_valid); else pass_cnt++;
      tot_cnt++; if (bus_rr.out_data !== 32'hDEAD_BEEF) $display("FAIL bp_drain_hold got=%h exp=deadbeef", bus_rr.out_data); else pass_cnt++;
      bus_rr.in_data[31:0] = 32'h1000_0000;
   endtask

   task automatic test_skip_wrap();
      bus_rr.out_ready = 1'b1;
      bus_rr.in_valid  = 4'b0010;   // park ptr on channel 1
      tick();
      tot_cnt++; if (bus_rr.out_chan !== 2'd1) $display("FAIL sw_setup got=%0d exp=1", bus_rr.out_chan); else pass_cnt++;
      bus_rr.in_valid = 4'b1001;
      #1;
      tot_cnt++; if (bus_rr.in_ready !== 4'b1000) $display("FAIL sw_ready1 got=%b exp=1000", bus_rr.in_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (bus_rr.out_chan !== 2'd3) $display("FAIL sw_chan1 got=%0d exp=3", bus_rr.out_chan); else pass_cnt++;
      tot_cnt++; if (bus_rr.in_ready !== 4'b0001) $display("FAIL sw_ready2 got=%b exp=0001", bus_rr.in_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (bus_rr.out_chan !== 2'd0 || bus_rr.out_valid !== 1'b1) $display("FAIL sw_chan2 got=%0d/%b exp=0/1", bus_rr.out_chan, bus_rr.out_valid); else pass_cnt++;
      bus_rr.in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_fixed();
      bus_fx.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
      bus_fx.sel       = 2'd2;
      bus_fx.in_valid  = 4'b1111;
      bus_fx.out_ready = 1'b1;
      #1;
      tot_cnt++; if (bus_fx.in_ready !== 4'b0100) $display("FAIL fx_ready got=%b exp=0100", bus_fx.in_ready); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         tot_cnt++; if (bus_fx.out_data !== 32'h33 || bus_fx.out_chan !== 2'd2 || bus_fx.out_valid !== 1'b1)
            $display("FAIL fx_out[%0d] got=%h/%0d/%b exp=33/2/1", k, bus_fx.out_data, bus_fx.out_chan, bus_fx.out_valid);
         else pass_cnt++;
      end
      bus_fx.sel      = 2'd3;
      bus_fx.in_valid = 4'b0111;
      #1;
      tot_cnt++; if (bus_fx.in_ready !== 4'b1000) $display("FAIL fx_ready3 got=%b exp=1000", bus_fx.in_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (bus_fx.out_valid !== 1'b0) $display("FAIL fx_drain got=%b exp=0", bus_fx.out_valid); else pass_cnt++;
      bus_fx.in_valid = 4'b0000;
   endtask

   task automatic test_reset_mid();
      bus_rr.in_data[31:0] = 32'h55;
      bus_rr.in_valid  = 4'b0001;
      bus_rr.out_ready = 1'b0;
      tick();
      tot_cnt++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 32'h55) $display("FAIL rm_load got=%b/%h exp=1/55", bus_rr.out_valid, bus_rr.out_data); else pass_cnt++;
      reset_n          = 1'b0;
      bus_rr.in_valid  = 4'b1111;
      bus_rr.out_ready = 1'b1;
      bus_rr.in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      #1;
      tot_cnt++; if (bus_rr.in_ready !== 4'b0000) $display("FAIL rm_ready got=%b exp=0000", bus_rr.in_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (bus_rr.out_valid !== 1'b0 || bus_rr.out_data !== 32'h0) $display("FAIL rm_clear got=%b/%h exp=0/0", bus_rr.out_valid, bus_rr.out_data); else pass_cnt++;
      reset_n = 1'b1;
      #1;
      tot_cnt++; if (bus_rr.in_ready !== 4'b0001) $display("FAIL rm_ready_post got=%b exp=0001", bus_rr.in_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (bus_rr.out_chan !== 2'd0 || bus_rr.out_data !== 32'h1000_0000 || bus_rr.out_valid !== 1'b1)
         $display("FAIL rm_first got=%0d/%h/%b exp=0/10000000/1", bus_rr.out_chan, bus_rr.out_data, bus_rr.out_valid);
      else pass_cnt++;
   endtask

   initial begin
      reset_n          = 1'b0;
      bus_rr.in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      bus_rr.in_valid  = '0;
      bus_rr.sel       = '0;
      bus_rr.out_ready = 1'b0;
      bus_fx.in_data   = '0;
      bus_fx.in_valid  = '0;
      bus_fx.sel       = '0;
      bus_fx.out_ready = 1'b0;
      test_reset();
      test_rr_fairness();
      test_backpressure();
      test_skip_wrap();
      test_fixed();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
- REQ-001 Parameter W, default 32: data width of every channel and of the output, in bits.
- REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
- REQ-003 Parameter MODE, default 1: 0 selects fixed mode (channel chosen by sel); 1 selects round-robin mode.
- REQ-004 Parameter SW, default 2: width of sel and out_chan; SW = ceil(log2(N)).
- REQ-005 clk  input  1  single clock; all state updates on the rising edge.
- REQ-006 reset_n  input  1  reset; synchronous and active-low.
- REQ-007 in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- REQ-008 in_valid  input  N  bit i set: channel i presents data.
- REQ-009 in_ready  output  N  bit i set: channel i's data is accepted this cycle if valid.
- REQ-010 sel  input  SW  channel index used in fixed mode; ignored in round-robin mode.
- REQ-011 out_data  output  W  registered output data.
- REQ-012 out_valid  output  1  out_data holds an unconsumed word.
- REQ-013 out_ready  input  1  downstream accepts out_data this cycle.
- REQ-014 out_chan  output  SW  index of the channel that sourced out_data.

Function
- REQ-015 The block SHALL hold at most one word, in an output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
- REQ-016 load_ok SHALL be 1 when out_valid=0 or out_ready=1; it is combinational.
- REQ-017 Fixed mode: grant SHALL equal sel; when sel >= N, there SHALL be no grant and all in_ready SHALL be 0.
- REQ-018 Round-robin mode: grant SHALL be the first channel with in_valid set, searching ptr+1, ptr+2, ... modulo N and ending at ptr; with no valid channel there SHALL be no grant.
- REQ-019 in_ready[i] SHALL be 1 only when load_ok=1 and grant=i; at most one in_ready bit SHALL be high in any cycle.
- REQ-020 Acceptance:
  - A transfer occurs when in_valid[grant] and in_ready[grant] are both 1.
  - On the next edge, out_data SHALL take that channel's word, out_chan SHALL take grant, and out_valid SHALL become 1.
  - Latency is 1 cycle from input to output.
- REQ-021 Simultaneous drain and load: when out_valid, out_ready and a transfer all occur in the same cycle, the new word SHALL replace the old one with out_valid held at 1, giving one word per cycle of throughput.
- REQ-022 Drain only: when out_ready=1 with no transfer, out_valid SHALL become 0; out_data and out_chan SHALL hold their values.
- REQ-023 Stall: when out_valid=1 and out_ready=0, out_data, out_valid and out_chan SHALL remain stable and all in_ready SHALL be 0.
- REQ-024 ptr SHALL update to the granted index only on an accepted transfer; ptr SHALL not update in fixed mode.
- REQ-025 Wrap-around: with ptr=N-1, the search SHALL start at channel 0.
- REQ-026 in_ready SHALL not depend on out_data.
- REQ-027 Every in_ready bit SHALL be 0 while reset_n=0.

Reset
- REQ-028 On a clk edge with reset_n=0, the block SHALL set out_valid=0, out_data=0, out_chan=0 and ptr=N-1, so channel 0 has first priority after reset.
- REQ-029 Reset mid-operation SHALL discard any held word without presenting it.
- REQ-030 Inputs presented during the reset cycle SHALL not be accepted.

Verification
- REQ-031 Round-robin fairness: N=4, MODE=1, all in_valid=1 and out_ready=1 continuously after reset. The required response is:
  - out_chan sequence 0,1,2,3,0.
  - out_valid=1 from the 2nd cycle with no bubbles.
- REQ-032 Backpressure: one word 0xDEADBEEF is accepted, then out_ready=0 for 5 cycles. The required response is:
  - out_data=0xDEADBEEF stable for all 5 cycles.
  - All in_ready=0 for all 5 cycles.
  - With out_ready=1 and no input, out_valid falls the following cycle.
- REQ-033 Skip and wrap: ptr=1, with in_valid=4'b1001. The required response is:
  - Grant goes to channel 3, then channel 0.
  - Channels 1 and 2 never see in_ready.
- REQ-034 Fixed mode: MODE=0, sel=2, in_valid=4'b1111 with data 0x11,0x22,0x33,0x44. The required response is:
  - out_data=0x33 and out_chan=2 on every output cycle.
  - With sel=3 and in_valid[3]=0, out_valid=0 after the drain.
- REQ-035 Reset mid-operation: out_valid=1 holding 0x55, then reset_n=0 for one cycle. The required response is:
  - out_valid=0 and out_data=0 on the next cycle.
  - The next grant with all inputs valid is channel 0.
